btn_debounce_ev: RTL and testbench

Upstream button-conditioning stage for the board-level counter/seven-segment designs. It synchronizes a raw tact-switch input, debounces it with a counter-qualified state machine, and produces a clean level plus single-cycle event strobes: press, release, long-press and optional auto-repeat. Its `key` output is a drop-in replacement for the existing debounce stage's `key`. Downstream counters can consume `key_press` directly instead of running their own edge detector.

---
 rtl/btn_debounce_ev.sv | 207 ++++++++++++++++++++
 tb/tb_btn_debounce_ev.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_ev.sv
// Button conditioner: 2-FF synchronizer, counter-qualified debounce FSM, registered level and
// one-cycle press/release/long/repeat strobes. Define BTN_DEBOUNCE_AUTORPT_EN for auto-repeat.
module btn_debounce_ev #(
  parameter int unsigned DEB_CYC  = 1_000_000,
  parameter int unsigned LONG_CYC = 50_000_000,
  parameter int unsigned RPT_CYC  = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btnr,
  output logic key,
  output logic key_press,
  output logic key_rel,
  output logic key_long,
  output logic key_rpt
);

  localparam int unsigned MaxDl  = (DEB_CYC > LONG_CYC) ? DEB_CYC : LONG_CYC;
  localparam int unsigned MaxCyc = (MaxDl > RPT_CYC) ? MaxDl : RPT_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t DebLast  = cnt_t'(DEB_CYC - 1);
  localparam cnt_t LongLast = cnt_t'(LONG_CYC - 1);
  localparam cnt_t CntOne   = cnt_t'(1);
`ifdef BTN_DEBOUNCE_AUTORPT_EN
  localparam cnt_t RptLast  = cnt_t'(RPT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StPressChk,
    StHeld,
    StRepeat,
    StRelChk
  } state_e;

  logic   s1_q, btn_s_q;
  state_e state_q, state_d;
  cnt_t   deb_cnt_q, deb_cnt_d;
  cnt_t   hold_cnt_q, hold_cnt_d;
  logic   long_done_q, long_done_d;
  logic   key_q, key_d;
  logic   press_q, press_d;
  logic   rel_q, rel_d;
  logic   long_q, long_d;
`ifdef BTN_DEBOUNCE_AUTORPT_EN
  cnt_t   rpt_cnt_q, rpt_cnt_d;
  logic   rpt_q, rpt_d;
`endif

  // Raw button is asynchronous; only btn_s_q feeds decisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      s1_q    <= btnr;
      btn_s_q <= s1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    key_d       = key_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    long_d      = 1'b0;
`ifdef BTN_DEBOUNCE_AUTORPT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_d       = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        key_d = 1'b0;
        if (btn_s_q) begin
          state_d   = StPressChk;
          deb_cnt_d = '0;
        end
      end

      StPressChk: begin
        if (!btn_s_q) begin
          state_d = StIdle;
        end else if (deb_cnt_q == DebLast) begin
          state_d     = StHeld;
          key_d       = 1'b1;
          press_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + CntOne;
        end
      end

      StHeld: begin
        if (!btn_s_q) begin
          state_d   = StRelChk;
          deb_cnt_d = '0;
        end else if (hold_cnt_q == LongLast) begin
`ifdef BTN_DEBOUNCE_AUTORPT_EN
          long_d      = 1'b1;
          long_done_d = 1'b1;
          rpt_cnt_d   = '0;
          state_d     = StRepeat;
`else
          // hold_cnt stays saturated; long_done keeps key_long from re-firing.
          if (!long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + CntOne;
        end
      end

`ifdef BTN_DEBOUNCE_AUTORPT_EN
      StRepeat: begin
        if (!btn_s_q) begin
          state_d   = StRelChk;
          deb_cnt_d = '0;
        end else if (rpt_cnt_q == RptLast) begin
          rpt_d     = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + CntOne;
        end
      end
`endif

      StRelChk: begin
        // A bounce resumes the hold phase with its counters untouched.
        if (btn_s_q) begin
`ifdef BTN_DEBOUNCE_AUTORPT_EN
          state_d = long_done_q ? StRepeat : StHeld;
`else
          state_d = StHeld;
`endif
        end else if (deb_cnt_q == DebLast) begin
          state_d = StIdle;
          key_d   = 1'b0;
          rel_d   = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StIdle;
        key_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      key_q       <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      key_q       <= key_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
    end
  end

`ifdef BTN_DEBOUNCE_AUTORPT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_q <= '0;
      rpt_q     <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_q     <= rpt_d;
    end
  end

  assign key_rpt = rpt_q;
`else
  assign key_rpt = 1'b0;
`endif

  assign key       = key_q;
  assign key_press = press_q;
  assign key_rel   = rel_q;
  assign key_long  = long_q;

  a_strobe_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({key_press, key_rel, key_long, key_rpt}));

endmodule

// File: tb/tb_btn_debounce_ev.sv
// Scoreboard bench for btn_debounce_ev: stimulus pushes expected strobes (cycle, kind) and a
// negedge monitor pops and compares each strobe the DUT presents.
module tb_btn_debounce_ev;

  localparam int KPress = 0;
  localparam int KRel   = 1;
  localparam int KLong  = 2;
  localparam int KRpt   = 3;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic btnr;
  logic key, key_press, key_rel, key_long, key_rpt;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];

  btn_debounce_ev #(
    .DEB_CYC  (8),
    .LONG_CYC (32),
    .RPT_CYC  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btnr      (btnr),
    .key       (key),
    .key_press (key_press),
    .key_rel   (key_rel),
    .key_long  (key_long),
    .key_rpt   (key_rpt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  // Call at a negedge; edge "1" of the press/release latency is the next posedge.
  task automatic set_btn(input logic v, output int t);
    btnr = v;
    t    = cyc;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key"}, int'(key), 0);
    chk({tag, "_press"}, int'(key_press), 0);
    chk({tag, "_rel"}, int'(key_rel), 0);
    chk({tag, "_long"}, int'(key_long), 0);
    chk({tag, "_rpt"}, int'(key_rpt), 0);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  initial begin
    int  kind;
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst && (key_press || key_rel || key_long || key_rpt)) begin
        kind = key_press ? KPress : key_rel ? KRel : key_long ? KLong : KRpt;
        chk("strobe_onehot", $countones({key_press, key_rel, key_long, key_rpt}), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", kind, -1);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", kind, e.kind);
          chk("strobe_cycle", cyc, e.cyc);
          chk("key_level", int'(key), (e.kind == KRel) ? 0 : 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int r;
    int q;
    rst  = 1'b0;
    btnr = 1'b0;
    wait_neg(3);
    chk_all_zero("reset");
    rst = 1'b1;
    wait_neg(5);
    chk("idle_key", int'(key), 0);

    // Clean press, 20-cycle hold: no long press.
    set_btn(1'b1, t);
    push(t + 11, KPress);
    wait_neg(20);
    set_btn(1'b0, r);
    push(r + 11, KRel);
    wait_neg(20);
    chk("drain_clean", exp_q.size(), 0);

    // Bounce rejection: two 5-cycle pulses separated by 3 low cycles.
    set_btn(1'b1, t);
    wait_neg(5);
    set_btn(1'b0, t);
    wait_neg(3);
    set_btn(1'b1, t);
    wait_neg(5);
    set_btn(1'b0, t);
    wait_neg(3);
    chk("bounce_key", int'(key), 0);
    chk("bounce_drain", exp_q.size(), 0);
    set_btn(1'b1, t);
    push(t + 11, KPress);
    wait_neg(14);

    // Release with bounce from HELD: low 4, high 2, then stable low.
    set_btn(1'b0, r);
    wait_neg(4);
    set_btn(1'b1, r);
    wait_neg(2);
    set_btn(1'b0, r);
    wait_neg(5);
    chk("relbounce_key_held", int'(key), 1);
    push(r + 11, KRel);
    wait_neg(15);
    chk("drain_relbounce", exp_q.size(), 0);

    // Long hold: release lands after the fifth repeat point.
    set_btn(1'b1, t);
    push(t + 11, KPress);
    push(t + 43, KLong);
`ifdef BTN_DEBOUNCE_AUTORPT_EN
    for (int i = 1; i <= 5; i++) push(t + 43 + 8 * i, KRpt);
`endif
    wait_neg(82);
    set_btn(1'b0, r);
    push(r + 11, KRel);
    wait_neg(20);
    chk("drain_long", exp_q.size(), 0);

    // Async reset during the hold, then requalify with the button still down.
    set_btn(1'b1, t);
    push(t + 11, KPress);
    push(t + 43, KLong);
`ifdef BTN_DEBOUNCE_AUTORPT_EN
    push(t + 51, KRpt);
`endif
    wait_neg(51);
    #1 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    chk("drain_pre_rst", exp_q.size(), 0);
    wait_neg(3);
    rst = 1'b1;
    q   = cyc;
    push(q + 11, KPress);
    wait_neg(20);
    set_btn(1'b0, r);
    push(r + 11, KRel);
    wait_neg(20);
    chk("drain_post_rst", exp_q.size(), 0);
    chk("final_key", int'(key), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
